// File: rtl/dmem_pkg.sv
// Shared types for the data-memory arbiter: default widths, owner state, request bundle.
package dmem_pkg;
  localparam int DMEM_ADDR_W = 8;
  localparam int DMEM_DATA_W = 8;

  typedef enum logic [1:0] {OWN_IDLE, OWN_CPU, OWN_EXT} owner_e;

  typedef struct packed {
    logic                   we;
    logic [DMEM_ADDR_W-1:0] addr;
    logic [DMEM_DATA_W-1:0] wdata;
  } req_t;
endpackage

// File: rtl/dmem_arbiter_rd_capture.sv
// Per-requester read-return register: captures memory data on a read grant, flags it for one cycle.
module dmem_rd_capture #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cap_en,
  input  logic [DATA_W-1:0] d,
  output logic              rvalid,
  output logic [DATA_W-1:0] rdata
);
  logic              rvalid_q;
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      rvalid_q <= cap_en;
      if (cap_en) rdata_q <= d;
    end
  end

  assign rvalid = rvalid_q;
  assign rdata  = rdata_q;
endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates the single-port data memory between the CPU and an external requester.
// Optional atomic EXT bursts when DMEM_ARB_LOCK_EN is defined (adds ext_lock input).
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int ADDR_W   = DMEM_ADDR_W,
  parameter int DATA_W   = DMEM_DATA_W,
  parameter int MAX_HOLD = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              ext_req,
  input  logic              ext_we,
  input  logic [ADDR_W-1:0] ext_addr,
  input  logic [DATA_W-1:0] ext_wdata,
`ifdef DMEM_ARB_LOCK_EN
  input  logic              ext_lock,
`endif
  output logic              ext_gnt,
  output logic              ext_rvalid,
  output logic [DATA_W-1:0] ext_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall
);
  owner_e     state_q, state_d;
  logic [3:0] hold_q, hold_d;
  logic       hold_full, lock_act, ext_wins;
  req_t       cpu_r, ext_r, sel;

  assign cpu_r     = '{we: cpu_we, addr: cpu_addr, wdata: cpu_wdata};
  assign ext_r     = '{we: ext_we, addr: ext_addr, wdata: ext_wdata};
  assign hold_full = (hold_q == 4'(MAX_HOLD));

`ifdef DMEM_ARB_LOCK_EN
  logic lock_q;
  // Lock only survives while EXT still owns the port and keeps both req and lock high.
  assign lock_act = lock_q & (state_q == OWN_EXT) & ext_req & ext_lock;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) lock_q <= 1'b0;
    else       lock_q <= ext_gnt & ext_lock;
  end
`else
  logic state_unused;
  assign lock_act     = 1'b0;
  assign state_unused = ^state_q;
`endif

  always_comb begin
    state_d  = OWN_IDLE;
    hold_d   = hold_q;
    sel      = '0;
    ext_wins = ext_req & (~cpu_req | hold_full | lock_act);
    cpu_gnt  = cpu_req & ~ext_wins & ~reset;
    ext_gnt  = ext_req & ext_wins & ~reset;
    if (cpu_gnt) begin
      state_d = OWN_CPU;
      sel     = cpu_r;
      hold_d  = ext_req ? (hold_full ? hold_q : hold_q + 4'd1) : 4'd0;
    end else if (ext_gnt) begin
      state_d = OWN_EXT;
      sel     = ext_r;
      hold_d  = 4'd0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= OWN_IDLE;
      hold_q  <= 4'd0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
    end
  end

  assign mem_addr  = sel.addr;
  assign mem_wdata = sel.wdata;
  assign mem_we    = sel.we;
  assign stall     = cpu_req & ~cpu_gnt & ~reset;

  dmem_rd_capture #(.DATA_W(DATA_W)) u_cpu_rd (
    .clk    (clk),
    .reset  (reset),
    .cap_en (cpu_gnt & ~cpu_we),
    .d      (mem_rdata),
    .rvalid (cpu_rvalid),
    .rdata  (cpu_rdata)
  );

  dmem_rd_capture #(.DATA_W(DATA_W)) u_ext_rd (
    .clk    (clk),
    .reset  (reset),
    .cap_en (ext_gnt & ~ext_we),
    .d      (mem_rdata),
    .rvalid (ext_rvalid),
    .rdata  (ext_rdata)
  );
endmodule
